// File: rtl/apb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_cfg_pkg
// Purpose  : Shared types and defaults for the APB configuration master:
//            FSM state encoding, default bus widths and timeout limit.
// Revision : 1.0 - initial release
// ============================================================================
package apb_cfg_pkg;

  // Transfer phases of the master; 2-bit explicit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned C_DEFAULT_ADDR_W         = 8;
  localparam int unsigned C_DEFAULT_DATA_W         = 32;
  localparam int unsigned C_DEFAULT_TIMEOUT_CYCLES = 255;
  // Wide enough for the largest legal timeout (65535).
  localparam int unsigned C_TMO_CNT_W              = 16;

endpackage
`default_nettype wire

// File: rtl/apb_cfg_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_cfg_master_if
// Purpose  : Bundles the command/response handshake and the APB bus of the
//            configuration master. 'master' is the view of the block that
//            drives APB; 'slave' is the view of its environment (command
//            source, response sink and APB completer).
// Revision : 1.0 - initial release
// ============================================================================
interface apb_cfg_master_if
  import apb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = C_DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = C_DEFAULT_DATA_W
);
  // Command channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;
  // APB toward the config block
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout_ctr
// Purpose  : Counts ACCESS wait cycles and flags the cycle on which the count
//            reaches LIMIT. Only instantiated when APB_MASTER_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timeout_ctr
  import apb_cfg_pkg::*;
#(
  parameter int unsigned LIMIT = C_DEFAULT_TIMEOUT_CYCLES
) (
  input  wire  clk,
  input  wire  resetn,
  input  wire  i_clr,
  input  wire  i_inc,
  output logic o_expired
);

  localparam logic [C_TMO_CNT_W-1:0] C_LIMIT_M1 = C_TMO_CNT_W'(LIMIT - 1);

  logic [C_TMO_CNT_W-1:0] count_q;
  logic [C_TMO_CNT_W-1:0] count_d;

  // Clear wins over increment; the counter simply holds once the FSM leaves ACCESS.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // Expiry is flagged on the wait cycle whose increment brings the count to LIMIT.
  assign o_expired = i_inc && (count_q == C_LIMIT_M1);

  // Wait-cycle counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cfg_master
// Purpose  : Converts single register commands into APB transfers
//            (IDLE -> SETUP -> ACCESS -> RESP) and returns one response per
//            command. All outputs are registered.
//            Optional ACCESS timeout: define APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cfg_master
  import apb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W         = C_DEFAULT_ADDR_W,
  parameter int unsigned DATA_W         = C_DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT_CYCLES
) (
  input  wire              clk,
  input  wire              resetn,
  apb_cfg_master_if.master bus,
  output logic             busy
);

  // Reject an out-of-range timeout at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_cfg_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  apb_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic              timeout_w;

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter is cleared on the SETUP->ACCESS edge and counts ACCESS cycles without PREADY.
  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk       (clk),
    .resetn    (resetn),
    .i_clr     (state_q == ST_SETUP),
    .i_inc     ((state_q == ST_ACCESS) && !bus.PREADY),
    .o_expired (timeout_w)
  );
`else
  // Without the timeout option ACCESS waits for PREADY forever.
  assign timeout_w = 1'b0;
`endif

  // Next-state and next-output decode; every register holds unless its phase changes it.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        // Only a cycle that already shows req_ready=1 may accept.
        if (bus.req_valid && req_ready_q) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = bus.req_write;
          paddr_d     = bus.req_addr;
          pwdata_d    = bus.req_write ? bus.req_wdata : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.PREADY || timeout_w) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          rsp_valid_d = 1'b1;
          // PREADY takes priority: a completer answering on the last allowed cycle wins.
          rsp_error_d = !bus.PREADY;
          rsp_rdata_d = (bus.PREADY && !pwrite_q) ? bus.PRDATA : '0;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything including req_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cfg_master
// Purpose  : Self-checking bench for apb_cfg_master. The bench plays command
//            source, response sink and APB completer (a register array), and
//            predicts responses from a separate reference register array.
//            Timeout scenario runs only with APB_MASTER_TIMEOUT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cfg_master;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] slave_mem [256];
  logic [31:0] ref_mem   [256];

  apb_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cfg_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_psel"},      32'(bus.PSEL),      32'd0);
    check({pfx, "_penable"},   32'(bus.PENABLE),   32'd0);
    check({pfx, "_pwrite"},    32'(bus.PWRITE),    32'd0);
    check({pfx, "_paddr"},     32'(bus.PADDR),     32'd0);
    check({pfx, "_pwdata"},    bus.PWDATA,         32'd0);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
    check({pfx, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
    check({pfx, "_busy"},      32'(busy),          32'd0);
    check({pfx, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  // One complete command: accept, SETUP, ACCESS (n_wait waits or stuck), RESP held 'hold' cycles.
  // With queue_next, the next command is presented on req_* throughout RESP.
  task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input int n_wait, input bit stuck, input int hold,
                        input bit queue_next, input bit nwr, input logic [7:0] naddr,
                        input logic [31:0] nwdata);
    logic [31:0] exp_rd;
    logic [31:0] exp_pwdata;
    bit          exp_err;
    int          w;
    int          guard;
    exp_err    = 1'b0;
    exp_rd     = (wr || stuck) ? 32'h0 : ref_mem[addr];
    exp_pwdata = wr ? wdata : 32'h0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 16) begin
      tick();
      guard++;
    end
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    check("idle_psel", 32'(bus.PSEL), 32'd0);
    tick();
    // Scramble the command bus so only latched values can appear on APB.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 8'($urandom);
    bus.req_wdata = $urandom;
    check("setup_psel",      32'(bus.PSEL),      32'd1);
    check("setup_penable",   32'(bus.PENABLE),   32'd0);
    check("setup_pwrite",    32'(bus.PWRITE),    32'(wr));
    check("setup_paddr",     32'(bus.PADDR),     32'(addr));
    check("setup_pwdata",    bus.PWDATA,         exp_pwdata);
    check("setup_req_ready", 32'(bus.req_ready), 32'd0);
    check("setup_busy",      32'(busy),          32'd1);
    check("setup_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.PREADY = 1'b0;
    bus.PRDATA = $urandom;
    tick();
    w = 0;
    forever begin
      check("acc_psel",      32'(bus.PSEL),      32'd1);
      check("acc_penable",   32'(bus.PENABLE),   32'd1);
      check("acc_pwrite",    32'(bus.PWRITE),    32'(wr));
      check("acc_paddr",     32'(bus.PADDR),     32'(addr));
      check("acc_pwdata",    bus.PWDATA,         exp_pwdata);
      check("acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      if (!stuck && w == n_wait) begin
        if (bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
        bus.PRDATA = bus.PWRITE ? $urandom : slave_mem[bus.PADDR];
        bus.PREADY = 1'b1;
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = $urandom;
      end
      tick();
      if (!stuck && w == n_wait) break;
      w++;
      if (stuck && w == TMO) begin
        exp_err = 1'b1;
        break;
      end
    end
    bus.PREADY = 1'b0;
    bus.PRDATA = $urandom;
    if (wr && !stuck) ref_mem[addr] = wdata;
    check("resp_valid",     32'(bus.rsp_valid), 32'd1);
    check("resp_rdata",     bus.rsp_rdata,      exp_rd);
    check("resp_error",     32'(bus.rsp_error), 32'(exp_err));
    check("resp_psel",      32'(bus.PSEL),      32'd0);
    check("resp_penable",   32'(bus.PENABLE),   32'd0);
    check("resp_pwrite",    32'(bus.PWRITE),    32'd0);
    check("resp_paddr",     32'(bus.PADDR),     32'd0);
    check("resp_pwdata",    bus.PWDATA,         32'd0);
    check("resp_busy",      32'(busy),          32'd1);
    check("resp_req_ready", 32'(bus.req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (queue_next) begin
        bus.req_valid = 1'b1;
        bus.req_write = nwr;
        bus.req_addr  = naddr;
        bus.req_wdata = nwdata;
      end
      bus.rsp_ready = 1'b0;
      tick();
      check("hold_valid",     32'(bus.rsp_valid), 32'd1);
      check("hold_rdata",     bus.rsp_rdata,      exp_rd);
      check("hold_error",     32'(bus.rsp_error), 32'(exp_err));
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_psel",      32'(bus.PSEL),      32'd0);
    end
    if (queue_next) begin
      bus.req_valid = 1'b1;
      bus.req_write = nwr;
      bus.req_addr  = naddr;
      bus.req_wdata = nwdata;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_req_ready", 32'(bus.req_ready), 32'd1);
    check("done_busy",      32'(busy),          32'd0);
    check("done_psel",      32'(bus.PSEL),      32'd0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = $urandom;
      ref_mem[i]   = slave_mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;

    // Reset values appear without a clock edge.
    #2 resetn = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    check("rel_req_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("rel_req_ready_after_edge", 32'(bus.req_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // Zero-wait write of 1 to address 0.
    do_txn(1'b1, 8'h00, 32'h0000_0001, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Read of 0x1C with three wait states.
    slave_mem[8'h1C] = 32'hDEAD_BEEF;
    ref_mem[8'h1C]   = 32'hDEAD_BEEF;
    do_txn(1'b0, 8'h1C, 32'h0, 3, 1'b0, 0, 1'b0, 1'b0, 8'h00, 32'h0);

    // Back-to-back: second command waits through a 5-cycle response stall.
    do_txn(1'b1, 8'h10, 32'hA5A5_0001, 0, 1'b0, 5, 1'b1, 1'b0, 8'h10, 32'h0);
    do_txn(1'b0, 8'h10, 32'h0, 1, 1'b0, 0, 1'b0, 1'b0, 8'h00, 32'h0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck completer is aborted after TMO wait cycles; the next command is normal.
    do_txn(1'b0, 8'h20, 32'h0, 0, 1'b1, 1, 1'b0, 1'b0, 8'h00, 32'h0);
    do_txn(1'b1, 8'h20, 32'h1234_5678, 2, 1'b1 & 1'b0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
    do_txn(1'b0, 8'h20, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00, 32'h0);
`endif

    // Randomized commands against the reference register array.
    for (int k = 0; k < 24; k++) begin
      do_txn(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 3)), 1'b0,
             int'($urandom_range(0, 3)), 1'b0, 1'b0, 8'h00, 32'h0);
    end

    // Reset pulse during ACCESS: everything clears at once and no response follows.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h40;
    bus.req_wdata = 32'h0;
    bus.PREADY    = 1'b0;
    check("mid_pre_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("mid_in_access", 32'(bus.PENABLE), 32'd1);
    #2 resetn = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    check("midrel_req_ready_before_edge", 32'(bus.req_ready), 32'd0);
    tick();
    check("midrel_req_ready", 32'(bus.req_ready), 32'd1);
    check("midrel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrel_psel",      32'(bus.PSEL),      32'd0);
    tick();
    check("midrel_rsp_valid_later", 32'(bus.rsp_valid), 32'd0);

    // Normal operation after the aborted transfer.
    do_txn(1'b0, 8'h1C, 32'h0, 0, 1'b0, 1, 1'b0, 1'b0, 8'h00, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_cfg_master.md
APB_CFG_MASTER -- requirements
Module: apb_cfg_master

Interface
REQ-001 Parameter ADDR_W, default 8: APB address width; matches REG_ADDRWIDTH.
REQ-002 Parameter DATA_W, default 32: APB data width; matches REG_DATAWIDTH.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS wait cycles before abort; range 1..65535.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port req_valid, input, 1: a register command is offered.
REQ-007 Port req_ready, output, 1: the block accepts the command on this cycle.
REQ-008 Port req_write, input, 1: 1 = write, 0 = read.
REQ-009 Port req_addr, input, ADDR_W: register address.
REQ-010 Port req_wdata, input, DATA_W: write data; ignored for reads.
REQ-011 Port rsp_valid, output, 1: response available.
REQ-012 Port rsp_ready, input, 1: consumer takes the response.
REQ-013 Port rsp_rdata, output, DATA_W: read data; 0 for writes and aborts.
REQ-014 Port rsp_error, output, 1: the transaction timed out.
REQ-015 Ports PSEL, PENABLE, PWRITE (1 bit each), PADDR (ADDR_W) and PWDATA (DATA_W) are outputs; PRDATA (DATA_W) and PREADY (1 bit) are inputs; all follow APB semantics toward the config block.
REQ-016 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 FSM states are IDLE, SETUP, ACCESS and RESP; every output is registered.
REQ-018 req_ready shall be 1 only in IDLE; a command is accepted on a rising edge with req_valid=1 and req_ready=1, and its write flag, address and write data are latched.
REQ-019 Accept at edge N -> SETUP in cycle N+1: PSEL=1, PENABLE=0, PWRITE/PADDR/PWDATA driven from the latch (PWDATA=0 for reads).
REQ-020 SETUP -> ACCESS unconditionally: PSEL=1, PENABLE=1; address, control and data held stable.
REQ-021 ACCESS with PREADY=0 stays in ACCESS; ACCESS with PREADY=1 captures PRDATA (reads only, otherwise 0) and moves to RESP.
REQ-022 On entering RESP: PSEL, PENABLE, PWRITE, PADDR and PWDATA all go to 0; rsp_valid=1.
REQ-023 With zero wait states, rsp_valid is first high in cycle N+3; minimum issue interval is 4 cycles.
REQ-024 RESP holds rsp_valid, rsp_rdata and rsp_error stable until rsp_ready=1; then the FSM goes to IDLE and rsp_valid drops the next cycle.
REQ-025 A req_valid present during RESP is not accepted; it is accepted in IDLE no earlier than the following cycle.
REQ-026 A new command cannot start while rsp_valid=1; responses are never dropped or overwritten.

Reset
REQ-027 When resetn=0, with no clock required: state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error, busy and the timeout counter are 0; req_ready=0.
REQ-028 req_ready shall become 1 on the first rising edge after resetn deasserts.
REQ-029 Reset mid-transaction aborts the transaction and produces no response.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
REQ-031 With the macro defined, when the count reaches TIMEOUT_CYCLES the FSM goes to RESP with rsp_error=1 and rsp_rdata=0, and drives PSEL/PENABLE to 0.
REQ-032 Macro undefined: ACCESS waits indefinitely for PREADY, rsp_error is tied to 0, and no counter logic exists.

Structure
REQ-033 The shared package apb_cfg_pkg holds the FSM state typedef and the default width and timeout constants.
REQ-034 One sub-module, apb_timeout_ctr, is instantiated only under APB_MASTER_TIMEOUT_EN; all other logic is flat.

Verification
REQ-035 Write, addr 0x00, data 0x0000_0001, PREADY=1 -> SETUP and ACCESS carry those values; rsp_valid in cycle N+3 with rsp_rdata=0 and rsp_error=0.
REQ-036 Read, addr 0x1C, PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> ACCESS lasts 4 cycles; rsp_rdata=0xDEAD_BEEF.
REQ-037 Two back-to-back commands with rsp_ready held 0 for 5 cycles -> second command not accepted until one cycle after the rsp_ready handshake; first response stable throughout.
REQ-038 Macro defined, TIMEOUT_CYCLES=4, PREADY stuck at 0 -> rsp_error=1, rsp_rdata=0, PSEL=0 after 4 wait cycles; the next command completes normally.
REQ-039 resetn pulsed low during ACCESS -> all outputs 0 immediately, no rsp_valid, req_ready=1 one edge after release.
